// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU operand issuer and its decoder.
// Build with ALU_ISSUE_M_EXT_EN defined to accept RV32M encodings.
package alu_issue_pkg;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] LAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [4:0] SEL_ADD    = 5'b00000;
   localparam logic [4:0] SEL_SUB    = 5'b00010;
   localparam logic [4:0] SEL_SLL    = 5'b00100;
   localparam logic [4:0] SEL_SLT    = 5'b01000;
   localparam logic [4:0] SEL_SLTU   = 5'b01100;
   localparam logic [4:0] SEL_XOR    = 5'b10000;
   localparam logic [4:0] SEL_SRL    = 5'b10100;
   localparam logic [4:0] SEL_SRA    = 5'b10110;
   localparam logic [4:0] SEL_OR     = 5'b11000;
   localparam logic [4:0] SEL_AND    = 5'b11100;
   localparam logic [4:0] SEL_MUL    = 5'b00001;
   localparam logic [4:0] SEL_MULH   = 5'b00101;
   localparam logic [4:0] SEL_MULHSU = 5'b01001;
   localparam logic [4:0] SEL_MULHU  = 5'b01101;
   localparam logic [4:0] SEL_DIV    = 5'b10001;
   localparam logic [4:0] SEL_DIVU   = 5'b10101;
   localparam logic [4:0] SEL_REM    = 5'b11001;
   localparam logic [4:0] SEL_REMU   = 5'b11101;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_VALID  = 2'd2;

   // Clamp a latency parameter into the counter range, never below one.
   function automatic logic [CNT_W-1:0] lat_cycles(int cyc);
      logic [CNT_W-1:0] r;
      r = cyc[CNT_W-1:0];
      if (cyc < 1) r = LAT_ONE;
      if (cyc > (1 << CNT_W) - 1) r = '1;
      return r;
   endfunction

endpackage

// File: rtl/alu_sel_decode.sv
// OP / OP-IMM decoder: ALU select, immediate, legality and hold time.
// ALU_ISSUE_M_EXT_EN makes funct7=0000001 legal on OP.
module alu_sel_decode import alu_issue_pkg::*; #(
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 4,
   parameter int BASE_LAT = 1
) (
   input  logic [31:0]      instr,
   output logic [4:0]       select,
   output logic [4:0]       rd,
   output logic             imm_sel,
   output logic [31:0]      imm,
   output logic             illegal,
   output logic [CNT_W-1:0] lat
);

   localparam logic [CNT_W-1:0] L_BASE = lat_cycles(BASE_LAT);
   localparam logic [CNT_W-1:0] L_MUL  = lat_cycles(MUL_LAT);
   localparam logic [CNT_W-1:0] L_DIV  = lat_cycles(DIV_LAT);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_op;
   logic       is_imm;
   logic       unused_rs1;

   assign opcode     = instr[6:0];
   assign f3         = instr[14:12];
   assign f7         = instr[31:25];
   assign rd         = instr[11:7];
   assign is_op      = (opcode == OPC_OP);
   assign is_imm     = (opcode == OPC_OP_IMM);
   assign unused_rs1 = ^instr[19:15];

   always_comb begin
      select  = '0;
      imm_sel = 1'b0;
      imm     = {{20{instr[31]}}, instr[31:20]};
      illegal = 1'b1;
      lat     = L_BASE;
      unique case (1'b1)
         is_op: begin
            select = {f3, instr[30], instr[25]};
            if (f7 == F7_BASE) begin
               illegal = 1'b0;
            end else if (f7 == F7_ALT) begin
               illegal = !((f3 == F3_ADD) || (f3 == F3_SR));
            end else if (f7 == F7_MULDIV) begin
               lat = f3[2] ? L_DIV : L_MUL;
`ifdef ALU_ISSUE_M_EXT_EN
               illegal = 1'b0;
`else
               illegal = 1'b1;
`endif
            end
         end
         is_imm: begin
            imm_sel = 1'b1;
            // bit 30 is immediate data except on right shifts
            select  = {f3, (f3 == F3_SR) & instr[30], 1'b0};
            if (f3 == F3_SLL)
               illegal = (f7 != F7_BASE);
            else if (f3 == F3_SR)
               illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            else
               illegal = 1'b0;
         end
         default: ;
      endcase
`ifndef ALU_ISSUE_M_EXT_EN
      select[0] = 1'b0;
`endif
   end

endmodule

// File: rtl/alu_op_issuer.sv
// Issue stage: registers ALU operands, holds them for the op latency.
// ALU_ISSUE_M_EXT_EN enables MUL/DIV issue with MUL_LAT/DIV_LAT hold.
module alu_op_issuer import alu_issue_pkg::*; #(
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 4,
   parameter int BASE_LAT = 1
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] INSTR,
   input  logic [31:0] RS1_DATA,
   input  logic [31:0] RS2_DATA,
   output logic [31:0] DATA1,
   output logic [31:0] DATA2,
   output logic [4:0]  SELECT,
   output logic [4:0]  RD,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        ILLEGAL
);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   logic [4:0]       dec_sel;
   logic [4:0]       dec_rd;
   logic             dec_imm_sel;
   logic [31:0]      dec_imm;
   logic             dec_illegal;
   logic [CNT_W-1:0] dec_lat;

   logic take;
   logic load;
   logic multi;

   alu_sel_decode #(
      .MUL_LAT  (MUL_LAT),
      .DIV_LAT  (DIV_LAT),
      .BASE_LAT (BASE_LAT)
   ) u_dec (
      .instr   (INSTR),
      .select  (dec_sel),
      .rd      (dec_rd),
      .imm_sel (dec_imm_sel),
      .imm     (dec_imm),
      .illegal (dec_illegal),
      .lat     (dec_lat)
   );

   assign IN_READY  = (state == ST_IDLE) ||
                      ((state == ST_VALID) && OUT_READY);
   assign OUT_VALID = (state == ST_VALID);
   assign take      = IN_VALID && IN_READY;
   assign load      = take && !dec_illegal;
   assign multi     = (dec_lat > LAT_ONE);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         DATA1   <= '0;
         DATA2   <= '0;
         SELECT  <= '0;
         RD      <= '0;
         ILLEGAL <= 1'b0;
      end else begin
         ILLEGAL <= take && dec_illegal;
         if (load) begin
            // a retiring op in VALID is replaced in the same cycle
            DATA1  <= RS1_DATA;
            DATA2  <= dec_imm_sel ? dec_imm : RS2_DATA;
            SELECT <= dec_sel;
            RD     <= dec_rd;
            cnt    <= dec_lat - LAT_ONE;
            state  <= multi ? ST_SETTLE : ST_VALID;
         end else begin
            unique case (state)
               ST_IDLE: ;
               ST_SETTLE: begin
                  if (cnt <= LAT_ONE) begin
                     cnt   <= '0;
                     state <= ST_VALID;
                  end else begin
                     cnt <= cnt - LAT_ONE;
                  end
               end
               ST_VALID: begin
                  if (OUT_READY) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed scoreboard bench for alu_op_issuer.
// Define ALU_ISSUE_M_EXT_EN to exercise the RV32M paths.
module tb_alu_op_issuer;
   import alu_issue_pkg::*;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] INSTR;
   logic [31:0] RS1_DATA;
   logic [31:0] RS2_DATA;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic [4:0]  SELECT;
   logic [4:0]  RD;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic        ILLEGAL;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  sel;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 CLK = ~CLK;

   alu_op_issuer #(
      .MUL_LAT  (3),
      .DIV_LAT  (4),
      .BASE_LAT (1)
   ) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .INSTR     (INSTR),
      .RS1_DATA  (RS1_DATA),
      .RS2_DATA  (RS2_DATA),
      .DATA1     (DATA1),
      .DATA2     (DATA2),
      .SELECT    (SELECT),
      .RD        (RD),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .ILLEGAL   (ILLEGAL)
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(logic [31:0] d1, logic [31:0] d2,
                       logic [4:0] sel, logic [4:0] rd, int lat);
      exp_t e;
      e.d1  = d1;
      e.d2  = d2;
      e.sel = sel;
      e.rd  = rd;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Present one instruction; returns on the first negedge after acceptance.
   task automatic issue(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
      int n = 0;
      INSTR    = ins;
      RS1_DATA = r1;
      RS2_DATA = r2;
      IN_VALID = 1'b1;
      #1;
      while (!IN_READY && n < 20) begin
         @(negedge CLK);
         #1;
         n++;
      end
      if (!IN_READY) check("accept_timeout", {31'b0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
   endtask

   // Wait for OUT_VALID, then pop and compare against the scoreboard.
   task automatic retire(string tag);
      exp_t e;
      int   n = 1;
      while (!OUT_VALID && n < 20) begin
         check({tag, "_settle_rdy"}, {31'b0, IN_READY}, 32'd0);
         @(negedge CLK);
         n++;
      end
      if (sb.size() == 0) begin
         check({tag, "_sb_depth"}, sb.size(), 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_valid"}, {31'b0, OUT_VALID}, 32'd1);
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_d1"}, DATA1, e.d1);
      check({tag, "_d2"}, DATA2, e.d2);
      check({tag, "_sel"}, {27'b0, SELECT}, {27'b0, e.sel});
      check({tag, "_rd"}, {27'b0, RD}, {27'b0, e.rd});
   endtask

   task automatic expect_illegal(string tag, logic [31:0] d1,
                                 logic [31:0] d2, logic [4:0] sel);
      check({tag, "_pulse"}, {31'b0, ILLEGAL}, 32'd1);
      check({tag, "_ov"}, {31'b0, OUT_VALID}, 32'd0);
      check({tag, "_d1"}, DATA1, d1);
      check({tag, "_d2"}, DATA2, d2);
      check({tag, "_sel"}, {27'b0, SELECT}, {27'b0, sel});
      @(negedge CLK);
      check({tag, "_pulse_end"}, {31'b0, ILLEGAL}, 32'd0);
   endtask

   initial begin
      RESETN    = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      INSTR     = '0;
      RS1_DATA  = '0;
      RS2_DATA  = '0;
      #1;
      repeat (2) @(negedge CLK);
      check("rst_ov", {31'b0, OUT_VALID}, 32'd0);
      check("rst_ill", {31'b0, ILLEGAL}, 32'd0);
      check("rst_d1", DATA1, 32'd0);
      check("rst_d2", DATA2, 32'd0);
      check("rst_sel", {27'b0, SELECT}, 32'd0);
      check("rst_rd", {27'b0, RD}, 32'd0);
      check("rst_rdy", {31'b0, IN_READY}, 32'd1);
      RESETN = 1'b1;
      @(negedge CLK);

      push(32'd5, 32'd7, SEL_ADD, 5'd3, 1);
      issue(32'h002081B3, 32'd5, 32'd7);
      retire("add");

      push(32'd9, 32'h11, SEL_SUB, 5'd3, 1);
      issue(32'h402081B3, 32'd9, 32'h11);
      retire("sub");

      push(32'h80000000, 32'h00000404, SEL_SRA, 5'd5, 1);
      issue(32'h40435293, 32'h80000000, 32'hDEAD);
      retire("srai");

      push(32'd0, 32'hFFFFFFFF, SEL_ADD, 5'd1, 1);
      issue(32'hFFF00093, 32'd0, 32'h1234);
      retire("addi");

      push(32'h55, 32'hFFFFFC00, SEL_XOR, 5'd5, 1);
      issue(32'hC0034293, 32'h55, 32'h99);
      retire("xori");

      push(32'd3, 32'd4, SEL_SLTU, 5'd3, 1);
      issue(32'h0020B1B3, 32'd3, 32'd4);
      retire("sltu");

      issue(32'h4020F1B3, 32'hAAAA, 32'hBBBB);
      expect_illegal("and_b30", 32'd3, 32'd4, SEL_SLTU);
      check("and_b30_rdy", {31'b0, IN_READY}, 32'd1);

      issue(32'h40109093, 32'hCCCC, 32'hDDDD);
      expect_illegal("slli_f7", 32'd3, 32'd4, SEL_SLTU);

      issue(32'h00000003, 32'hEEEE, 32'hFFFF);
      expect_illegal("load_opc", 32'd3, 32'd4, SEL_SLTU);

`ifdef ALU_ISSUE_M_EXT_EN
      push(32'd100, 32'd7, SEL_DIV, 5'd7, 4);
      issue(32'h029443B3, 32'd100, 32'd7);
      retire("div");

      push(32'd6, 32'd8, SEL_MUL, 5'd1, 3);
      issue(32'h022080B3, 32'd6, 32'd8);
      retire("mul");
`else
      issue(32'h029443B3, 32'd100, 32'd7);
      expect_illegal("div_noext", 32'd3, 32'd4, SEL_SLTU);
      repeat (4) begin
         @(negedge CLK);
         check("div_noext_ov", {31'b0, OUT_VALID}, 32'd0);
      end

      issue(32'h022080B3, 32'd6, 32'd8);
      expect_illegal("mul_noext", 32'd3, 32'd4, SEL_SLTU);
`endif

      OUT_READY = 1'b0;
      push(32'd11, 32'd22, SEL_ADD, 5'd3, 1);
      issue(32'h002081B3, 32'd11, 32'd22);
      retire("bp");
      repeat (5) begin
         @(negedge CLK);
         check("bp_ov", {31'b0, OUT_VALID}, 32'd1);
         check("bp_rdy", {31'b0, IN_READY}, 32'd0);
         check("bp_d1", DATA1, 32'd11);
         check("bp_d2", DATA2, 32'd22);
         check("bp_sel", {27'b0, SELECT}, {27'b0, SEL_ADD});
      end
      OUT_READY = 1'b1;
      push(32'd33, 32'd44, SEL_ADD, 5'd3, 1);
      issue(32'h002081B3, 32'd33, 32'd44);
      retire("b2b");

`ifdef ALU_ISSUE_M_EXT_EN
      issue(32'h029443B3, 32'h77, 32'h3);
      check("mid_settle_ov", {31'b0, OUT_VALID}, 32'd0);
      check("mid_settle_d1", DATA1, 32'h77);
`else
      issue(32'h002081B3, 32'h77, 32'h3);
      OUT_READY = 1'b0;
      #1;
      check("mid_valid_ov", {31'b0, OUT_VALID}, 32'd1);
      check("mid_valid_d1", DATA1, 32'h77);
`endif
      RESETN = 1'b0;
      #1;
      check("arst_ov", {31'b0, OUT_VALID}, 32'd0);
      check("arst_d1", DATA1, 32'd0);
      check("arst_d2", DATA2, 32'd0);
      check("arst_sel", {27'b0, SELECT}, 32'd0);
      check("arst_rd", {27'b0, RD}, 32'd0);
      check("arst_rdy", {31'b0, IN_READY}, 32'd1);
      @(negedge CLK);
      RESETN    = 1'b1;
      OUT_READY = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("dropped_ov", {31'b0, OUT_VALID}, 32'd0);
      end

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Decode/issue stage that drives the RV32IM ALU operand and select inputs: DATA1, DATA2, SELECT.
- Accepts one decoded-register instruction per handshake, decodes OP and OP-IMM encodings into the 5-bit ALU select, and registers the operands.
- Holds operands stable for a programmable settle time, longer for M-extension ops, then presents them downstream with valid/ready.
- Sits between register-file read and the EX-stage ALU.

Parameters:
- MUL_LAT, 3, cycles operands are held before OUT_VALID for MUL/MULH/MULHSU/MULHU (funct7=0000001, funct3[2]=0).
- DIV_LAT, 4, cycles held before OUT_VALID for DIV/DIVU/REM/REMU (funct7=0000001, funct3[2]=1).
- BASE_LAT, 1, cycles held for all RV32I ops; minimum 1.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  upstream instruction valid.
- IN_READY  out  1  issuer can accept.
- INSTR  in  32  instruction word.
- RS1_DATA  in  32  rs1 value.
- RS2_DATA  in  32  rs2 value.
- DATA1  out  32  ALU operand 1, registered.
- DATA2  out  32  ALU operand 2, registered: rs2 or sign-extended imm.
- SELECT  out  5  ALU select, registered.
- RD  out  5  destination register, registered.
- OUT_VALID  out  1  operands settled, result usable.
- OUT_READY  in  1  downstream accepts.
- ILLEGAL  out  1  one-cycle pulse, unsupported encoding consumed.

Behaviour:
- Clock and reset: one clock CLK; RESETN asynchronous, active-low.
- Reset values: DATA1=0, DATA2=0, SELECT=0, RD=0, OUT_VALID=0, ILLEGAL=0, state=IDLE, counter=0.
- SELECT = {funct3, b1, b0}.
  - OP (0110011): b1=INSTR[30], b0=INSTR[25].
  - OP-IMM (0010011): b1=INSTR[30] only when funct3=101, else 0; b0=0.
- DATA2 for OP-IMM: {{20{INSTR[31]}},INSTR[31:20]}; for shifts, ALU uses the low bits only.
- Legal encodings:
  - OP funct7 ∈ {0000000; 0100000 with funct3 ∈ {000,101}; 0000001}.
  - OP-IMM shifts: funct3=001 needs INSTR[31:25]=0000000; funct3=101 needs 0000000 or 0100000.
  - Any other opcode is illegal.
- States:
  - IDLE: IN_READY=1. On IN_VALID:
    - Legal: load DATA1/DATA2/SELECT/RD, counter=LAT-1, go to SETTLE (or VALID if LAT=1).
    - Illegal: pulse ILLEGAL next cycle, keep outputs unchanged, stay in IDLE.
  - SETTLE: IN_READY=0, outputs frozen, counter decrements each cycle; go to VALID when counter reaches 0.
  - VALID: OUT_VALID=1, outputs frozen until OUT_READY.
    - On OUT_READY&&IN_VALID&&legal: reload the same cycle (back-to-back); OUT_VALID stays 1 only if the new LAT=1, else 0.
    - On OUT_READY without a new instruction: go to IDLE.
- IN_READY = (state==IDLE) || (state==VALID && OUT_READY).
- Latency: a LAT=1 op has OUT_VALID high on the cycle after acceptance; a DIV op after DIV_LAT cycles.
- Throughput: one per cycle for LAT=1 ops under continuous OUT_READY.
- Reset mid-SETTLE/VALID: everything returns to reset values immediately; the in-flight op is dropped.
- Illegal encoding in VALID with OUT_READY: current op retires, ILLEGAL pulses, state→IDLE.

Optional Feature:
- ALU_ISSUE_M_EXT_EN.
- Defined: funct7=0000001 is legal, and MUL_LAT/DIV_LAT apply.
- Undefined: funct7=0000001 is illegal (ILLEGAL pulse); MUL_LAT/DIV_LAT are unused; SELECT[0] is always 0.

Decomposition:
- Package alu_issue_pkg:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - funct7 constants;
  - 5-bit SELECT code constants (SEL_ADD, SEL_SUB … SEL_REMU);
  - state enum {IDLE, SETTLE, VALID}.
- Sub-module alu_sel_decode: combinational INSTR → {select, imm_sel, imm, illegal, lat}. The top holds the FSM, counter and registers.

Test Plan:
- RS1=5, RS2=7, INSTR=0x002081B3 (add x3,x1,x2), OUT_READY=1 → next cycle OUT_VALID=1, DATA1=5, DATA2=7, SELECT=00000, RD=3.
- INSTR=0x402081B3 (sub) → SELECT=00010. INSTR=0x40435293 (srai x5,x6,4) → SELECT=10110, DATA2=0x00000404, RD=5.
- INSTR=0xFFF00093 (addi x1,x0,-1) → SELECT=00000 even though INSTR[30]=1, DATA2=0xFFFFFFFF.
- With M_EXT_EN, INSTR=0x029443B3 (div x7,x8,x9), DIV_LAT=4 → OUT_VALID rises exactly 4 cycles after acceptance, SELECT=10001, IN_READY=0 throughout. Without M_EXT_EN → ILLEGAL pulse, OUT_VALID stays 0.
- Backpressure: OUT_READY=0 for 5 cycles in VALID → DATA1/DATA2/SELECT stable, IN_READY=0. Raise OUT_READY with the next add presented → back-to-back reload in the same cycle.
- INSTR=0x4020F1B3 (and with bit30) → ILLEGAL one cycle, outputs unchanged. Assert RESETN=0 mid-SETTLE of a div → all outputs 0 asynchronously, state IDLE.
